// File: rtl/video_sync_decoder.sv
// Video sync decoder: recovers pixel/line position and period measurements
// from asynchronous active-low H/V sync pulses, and tracks line-timing lock.
module video_sync_decoder #(
    parameter int unsigned H_ACTIVE_START = 76,
    parameter int unsigned H_PIXELS       = 320,
    parameter int unsigned V_ACTIVE_START = 19,
    parameter int unsigned V_PIXELS       = 240,
    parameter int unsigned H_TOL          = 2,
    parameter int unsigned LOCK_LINES     = 4,
    localparam int unsigned CNT_W         = 9
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             pixel_en_i,
    input  logic             h_sync_i,
    input  logic             v_sync_i,
    output logic [CNT_W-1:0] h_counter_o,
    output logic [CNT_W-1:0] v_counter_o,
    output logic [CNT_W-1:0] h_period_meas_o,
    output logic [CNT_W-1:0] v_period_meas_o,
    output logic             locked_o,
    output logic             active_o,
    output logic             frame_start_o
);

    localparam int unsigned DIFF_W  = CNT_W + 1;
    localparam int unsigned MATCH_W = 8;

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [DIFF_W-1:0] TOL     = DIFF_W'(H_TOL);

    localparam logic [DIFF_W-1:0] H_LO = DIFF_W'(H_ACTIVE_START);
    localparam logic [DIFF_W-1:0] H_HI = DIFF_W'(H_ACTIVE_START + H_PIXELS);
    localparam logic [DIFF_W-1:0] V_LO = DIFF_W'(V_ACTIVE_START);
    localparam logic [DIFF_W-1:0] V_HI = DIFF_W'(V_ACTIVE_START + V_PIXELS);

    // The reference line opens a run, so a run of LOCK_LINES equal lines
    // needs LOCK_LINES-1 in-tolerance comparisons.
    localparam logic [MATCH_W-1:0] LOCK_AT =
        MATCH_W'((LOCK_LINES > 1) ? (LOCK_LINES - 1) : 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    // Synchronizer and edge-detect state
    logic h_meta_q, h_sync_q, h_prev_q;
    logic v_meta_q, v_sync_q, v_prev_q;

    // Counters and measurements
    logic [CNT_W-1:0] h_cnt_q,  h_cnt_d;
    logic [CNT_W-1:0] h_meas_q, h_meas_d;
    logic [CNT_W-1:0] v_cnt_q,  v_cnt_d;
    logic [CNT_W-1:0] v_meas_q, v_meas_d;
    logic             v_pend_q, v_pend_d;
    logic             frame_start_q, frame_start_d;

    // Lock tracking
    state_e             state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               locked_q;
    logic               active_q;

    // Combinational helpers
    logic                     h_edge_c;
    logic                     v_edge_c;
    logic [CNT_W-1:0]         h_period_c;
    logic signed [DIFF_W-1:0] period_diff_c;
    logic [DIFF_W-1:0]        period_mag_c;
    logic                     in_tol_c;
    logic                     timeout_c;
    logic                     h_win_c;
    logic                     v_win_c;

    // Two-flop synchronizers, clocked every cycle, idle high
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            h_meta_q <= 1'b1;
            h_sync_q <= 1'b1;
            v_meta_q <= 1'b1;
            v_sync_q <= 1'b1;
        end else begin
            h_meta_q <= h_sync_i;
            h_sync_q <= h_meta_q;
            v_meta_q <= v_sync_i;
            v_sync_q <= v_meta_q;
        end
    end

    // Synchronized sync levels as seen at the previous pixel strobe
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            h_prev_q <= 1'b1;
            v_prev_q <= 1'b1;
        end else if (pixel_en_i) begin
            h_prev_q <= h_sync_q;
            v_prev_q <= v_sync_q;
        end
    end

    // Falling-edge detect and line-period comparison
    always_comb begin
        h_edge_c      = pixel_en_i & h_prev_q & ~h_sync_q;
        v_edge_c      = pixel_en_i & v_prev_q & ~v_sync_q;
        h_period_c    = h_cnt_q + CNT_ONE;
        period_diff_c = $signed({1'b0, h_period_c}) - $signed({1'b0, h_meas_q});
        period_mag_c  = period_diff_c[DIFF_W-1] ? DIFF_W'(-period_diff_c)
                                                : DIFF_W'(period_diff_c);
        in_tol_c      = (period_mag_c <= TOL);
    end

    // Next-state of pixel/line counters, measurements and frame pending
    always_comb begin
        h_cnt_d       = h_cnt_q;
        h_meas_d      = h_meas_q;
        v_cnt_d       = v_cnt_q;
        v_meas_d      = v_meas_q;
        v_pend_d      = v_pend_q;
        frame_start_d = 1'b0;

        if (h_edge_c) begin
            h_cnt_d  = '0;
            h_meas_d = h_period_c;
        end else if (pixel_en_i && (h_cnt_q != CNT_MAX)) begin
            h_cnt_d = h_cnt_q + CNT_ONE;
        end

        if (h_edge_c) begin
            if (v_pend_q || v_edge_c) begin
                v_cnt_d       = '0;
                v_meas_d      = v_cnt_q + CNT_ONE;
                v_pend_d      = 1'b0;
                frame_start_d = 1'b1;
            end else if (v_cnt_q != CNT_MAX) begin
                v_cnt_d = v_cnt_q + CNT_ONE;
            end
        end else if (v_edge_c) begin
            v_pend_d = 1'b1;
        end
    end

    // Line timeout: pixel counter reaches saturation without an H edge
    always_comb begin
        timeout_c = pixel_en_i & ~h_edge_c & (h_cnt_d == CNT_MAX);
    end

    // Lock FSM next-state
    always_comb begin
        state_d = state_q;
        match_d = match_q;

        case (state_q)
            ST_SEARCH: begin
                if (h_edge_c) begin
                    state_d = ST_ACQUIRE;
                    match_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (timeout_c) begin
                    state_d = ST_SEARCH;
                    match_d = '0;
                end else if (h_edge_c) begin
                    if (!in_tol_c) begin
                        match_d = '0;
                    end else if ((match_q + MATCH_ONE) >= LOCK_AT) begin
                        state_d = ST_LOCKED;
                        match_d = '0;
                    end else begin
                        match_d = match_q + MATCH_ONE;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout_c || (h_edge_c && !in_tol_c)) begin
                    state_d = ST_SEARCH;
                    match_d = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                match_d = '0;
            end
        endcase
    end

    // Visible-window decode from the registered counters
    always_comb begin
        h_win_c = ({1'b0, h_cnt_q} >= H_LO) && ({1'b0, h_cnt_q} < H_HI);
        v_win_c = ({1'b0, v_cnt_q} >= V_LO) && ({1'b0, v_cnt_q} < V_HI);
    end

    // Counter, measurement and FSM registers
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            h_cnt_q       <= '0;
            h_meas_q      <= '0;
            v_cnt_q       <= '0;
            v_meas_q      <= '0;
            v_pend_q      <= 1'b0;
            frame_start_q <= 1'b0;
            state_q       <= ST_SEARCH;
            match_q       <= '0;
            locked_q      <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            h_meas_q      <= h_meas_d;
            v_cnt_q       <= v_cnt_d;
            v_meas_q      <= v_meas_d;
            v_pend_q      <= v_pend_d;
            frame_start_q <= frame_start_d;
            state_q       <= state_d;
            match_q       <= match_d;
            locked_q      <= (state_d == ST_LOCKED);
        end
    end

    // Active window flag, one clock behind the counters
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            active_q <= 1'b0;
        end else begin
            active_q <= locked_q & h_win_c & v_win_c;
        end
    end

    assign h_counter_o     = h_cnt_q;
    assign v_counter_o     = v_cnt_q;
    assign h_period_meas_o = h_meas_q;
    assign v_period_meas_o = v_meas_q;
    assign locked_o        = locked_q;
    assign active_o        = active_q;
    assign frame_start_o   = frame_start_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder: line-table lock/measurement vectors
// plus hand-written frame, saturation and mid-line reset sequences.
module tb_video_sync_decoder;

    logic       clk;
    logic       reset_n;
    logic       pixel_en;
    logic       h_sync;
    logic       v_sync;
    logic [8:0] h_counter;
    logic [8:0] v_counter;
    logic [8:0] h_period_meas;
    logic [8:0] v_period_meas;
    logic       locked;
    logic       active;
    logic       frame_start;

    video_sync_decoder dut (
        .clock_i         (clk),
        .reset_n_i       (reset_n),
        .pixel_en_i      (pixel_en),
        .h_sync_i        (h_sync),
        .v_sync_i        (v_sync),
        .h_counter_o     (h_counter),
        .v_counter_o     (v_counter),
        .h_period_meas_o (h_period_meas),
        .v_period_meas_o (v_period_meas),
        .locked_o        (locked),
        .active_o        (active),
        .frame_start_o   (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;       // length of the line starting at this H edge
        int exp_meas;  // H_PERIOD_MEAS right after this edge
        bit exp_lk;    // LOCKED right after this edge
    } line_vec_t;

    line_vec_t tbl[21];
    bit        rst_lk[5];

    int n_err;
    int n_chk;
    int px_clks;
    bit hit;

    logic [8:0] s_h, s_v, s_hm, s_vm;
    logic       s_lk, s_fs, s_fs2, s_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One pixel period: drive syncs, let them settle, strobe PIXEL_EN, sample.
    task automatic px(input logic h, input logic v);
        h_sync = h;
        v_sync = v;
        repeat (2) @(negedge clk);
        pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
        s_h  = h_counter;
        s_v  = v_counter;
        s_hm = h_period_meas;
        s_vm = v_period_meas;
        s_lk = locked;
        s_fs = frame_start;
        @(negedge clk);
        s_act = active;
        s_fs2 = frame_start;
        repeat (px_clks - 4) @(negedge clk);
    endtask

    // Remaining pixels 1..len-1 of a line whose edge pixel was already driven.
    task automatic line_rest(input int len, input int hlow, input logic v);
        for (int k = 1; k < len; k++) px((k < hlow) ? 1'b0 : 1'b1, v);
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; pixel_en = 1'b0;
        h_sync = 1'b1; v_sync = 1'b1;
        n_err = 0; n_chk = 0; px_clks = 4; hit = 1'b0;

        tbl[0]  = '{400,   1, 1'b0};
        tbl[1]  = '{400, 400, 1'b0};
        tbl[2]  = '{400, 400, 1'b0};
        tbl[3]  = '{400, 400, 1'b0};
        tbl[4]  = '{400, 400, 1'b1};
        tbl[5]  = '{404, 400, 1'b1};
        tbl[6]  = '{400, 404, 1'b0};
        tbl[7]  = '{400, 400, 1'b0};
        tbl[8]  = '{400, 400, 1'b0};
        tbl[9]  = '{400, 400, 1'b0};
        tbl[10] = '{401, 400, 1'b1};
        tbl[11] = '{400, 401, 1'b1};
        tbl[12] = '{400, 400, 1'b1};
        tbl[13] = '{398, 400, 1'b1};
        tbl[14] = '{400, 398, 1'b1};
        tbl[15] = '{403, 400, 1'b1};
        tbl[16] = '{400, 403, 1'b0};
        tbl[17] = '{400, 400, 1'b0};
        tbl[18] = '{400, 400, 1'b0};
        tbl[19] = '{400, 400, 1'b0};
        tbl[20] = '{400, 400, 1'b1};
        rst_lk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held, with a pixel strobe that must be ignored
        repeat (3) @(negedge clk);
        pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
        @(negedge clk);
        chk("rst_hcnt", h_counter, 0);
        chk("rst_vcnt", v_counter, 0);
        chk("rst_hmeas", h_period_meas, 0);
        chk("rst_vmeas", v_period_meas, 0);
        chk("rst_locked", locked, 0);
        chk("rst_active", active, 0);
        chk("rst_fs", frame_start, 0);
        reset_n = 1'b1;

        // Line table: acquire, lock, stretch/drop, relock, tolerance edges
        for (int i = 0; i < 21; i++) begin
            px(1'b0, 1'b1);
            chk($sformatf("tbl%0d_meas", i), s_hm, tbl[i].exp_meas);
            chk($sformatf("tbl%0d_lock", i), s_lk, tbl[i].exp_lk);
            chk($sformatf("tbl%0d_hcnt", i), s_h, 0);
            line_rest(tbl[i].len, 49, 1'b1);
        end

        // Active window boundaries on a locked line (V_COUNTER = 22)
        px(1'b0, 1'b1);
        chk("act_lock", s_lk, 1);
        chk("act_meas", s_hm, 400);
        chk("act_vcnt", s_v, 22);
        chk("act_px0", s_act, 0);
        for (int k = 1; k < 400; k++) begin
            px((k < 49) ? 1'b0 : 1'b1, 1'b1);
            if (k == 75)  chk("act_px75", s_act, 0);
            if (k == 76)  chk("act_px76", s_act, 1);
            if (k == 395) begin
                chk("act_px395", s_act, 1);
                chk("act_hcnt395", s_h, 395);
            end
            if (k == 396) chk("act_px396", s_act, 0);
        end

        // Two short frames, V falling together with H
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 5; l++) begin
                px(1'b0, (l < 2) ? 1'b0 : 1'b1);
                if (l == 0) begin
                    chk($sformatf("frm%0d_fs", f), s_fs, 1);
                    chk($sformatf("frm%0d_fs_low", f), s_fs2, 0);
                    chk($sformatf("frm%0d_vcnt", f), s_v, 0);
                    chk($sformatf("frm%0d_vmeas", f), s_vm, (f == 0) ? 23 : 5);
                end
                if (l == 3) begin
                    chk($sformatf("frm%0d_vcnt_l3", f), s_v, 3);
                    chk($sformatf("frm%0d_fs_l3", f), s_fs, 0);
                end
                line_rest(40, 8, (l < 2) ? 1'b0 : 1'b1);
            end
        end

        // Third frame: V falls mid-line, frame starts on the following H edge
        px(1'b0, 1'b1);
        chk("frmc_nofs", s_fs, 0);
        chk("frmc_vcnt5", s_v, 5);
        chk("frmc_lock", s_lk, 1);
        for (int k = 1; k < 40; k++) begin
            px((k < 8) ? 1'b0 : 1'b1, (k < 20) ? 1'b1 : 1'b0);
            if (k == 20) begin
                chk("frmc_vedge_nofs", s_fs, 0);
                chk("frmc_vedge_vcnt", s_v, 5);
            end
            if (k == 30) chk("frmc_locked_inactive", s_act, 0);
        end
        px(1'b0, 1'b0);
        chk("frmc_fs", s_fs, 1);
        chk("frmc_fs_low", s_fs2, 0);
        chk("frmc_vcnt0", s_v, 0);
        chk("frmc_vmeas", s_vm, 6);
        line_rest(40, 8, 1'b0);
        for (int l = 2; l < 5; l++) begin
            px(1'b0, 1'b1);
            line_rest(40, 8, 1'b1);
        end

        // H_SYNC stuck high: saturation and timeout from LOCKED
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            px(1'b1, 1'b1);
            if (s_h == 9'd510) hit = 1'b1;
        end
        chk("sat_reach510", hit, 1);
        chk("sat_lock_510", s_lk, 1);
        px(1'b1, 1'b1);
        chk("sat_hcnt511", s_h, 511);
        chk("sat_timeout_lock", s_lk, 0);
        repeat (20) px(1'b1, 1'b1);
        chk("sat_hold511", s_h, 511);
        chk("sat_hold_lock", s_lk, 0);
        chk("sat_hold_active", s_act, 0);

        // Relock with slow pixel strobe, then one-clock reset mid-line
        px_clks = 16;
        for (int i = 0; i < 5; i++) begin
            px(1'b0, 1'b1);
            chk($sformatf("pre_rst_e%0d_lock", i + 1), s_lk, rst_lk[i]);
            line_rest(40, 8, 1'b1);
        end
        px(1'b0, 1'b1);
        chk("pre_rst_e6_lock", s_lk, 1);
        for (int k = 1; k <= 20; k++) px((k < 8) ? 1'b0 : 1'b1, 1'b1);
        reset_n  = 1'b0;
        pixel_en = 1'b1;
        @(negedge clk);
        reset_n  = 1'b1;
        pixel_en = 1'b0;
        chk("mid_rst_hcnt", h_counter, 0);
        chk("mid_rst_vcnt", v_counter, 0);
        chk("mid_rst_hmeas", h_period_meas, 0);
        chk("mid_rst_vmeas", v_period_meas, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_fs", frame_start, 0);
        repeat (15) @(negedge clk);
        for (int k = 21; k < 40; k++) px(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            px(1'b0, 1'b1);
            if (i == 0) chk("post_rst_e1_meas", s_hm, 20);
            chk($sformatf("post_rst_e%0d_lock", i + 1), s_lk, rst_lk[i]);
            line_rest(40, 8, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/video_sync_decoder.md
VIDEO_SYNC_DECODER -- requirements
Module: video_sync_decoder

Interface
REQ-001 Parameter H_ACTIVE_START, default 76: H_COUNTER value of the first visible pixel.
REQ-002 Parameter H_PIXELS, default 320: visible pixels per line.
REQ-003 Parameter V_ACTIVE_START, default 19: V_COUNTER value of the first visible line.
REQ-004 Parameter V_PIXELS, default 240: visible lines per frame.
REQ-005 Parameter H_TOL, default 2: allowed line-period deviation, in pixels.
REQ-006 Parameter LOCK_LINES, default 4: consecutive in-tolerance lines required to lock.
REQ-007 CLOCK  in  1  single system clock; all logic rising-edge.
REQ-008 RESET_N  in  1  synchronous, active-low reset.
REQ-009 PIXEL_EN  in  1  one-CLOCK pulse per pixel period; all sampling/counting occurs only on PIXEL_EN cycles.
REQ-010 H_SYNC  in  1  asynchronous horizontal sync, active-low pulse.
REQ-011 V_SYNC  in  1  asynchronous vertical sync, active-low pulse.
REQ-012 H_COUNTER  out  9  recovered pixel position in line.
REQ-013 V_COUNTER  out  9  recovered line position in frame.
REQ-014 H_PERIOD_MEAS  out  9  last measured line length, pixels.
REQ-015 V_PERIOD_MEAS  out  9  last measured frame length, lines.
REQ-016 LOCKED  out  1  high while the line timing is stable.
REQ-017 ACTIVE  out  1  high inside the visible window while LOCKED.
REQ-018 FRAME_START  out  1  one-CLOCK pulse at start of each recovered frame.

Function
REQ-019 H_SYNC and V_SYNC each SHALL pass through a 2-FF synchronizer clocked every CLOCK cycle.
REQ-020 Falling-edge detect SHALL compare the synchronized value with its value at the previous PIXEL_EN cycle, evaluated only on PIXEL_EN.
REQ-021 H edge on a PIXEL_EN cycle: H_COUNTER <= 0; H_PERIOD_MEAS <= H_COUNTER+1; otherwise H_COUNTER increments, saturating at 511.
REQ-022 H_COUNTER reaching 511 SHALL be a line timeout.
REQ-023 V edge SHALL set a pending flag; the next H edge (or the same PIXEL_EN cycle if both coincide) SHALL load V_COUNTER <= 0, V_PERIOD_MEAS <= V_COUNTER+1, clear pending, and pulse FRAME_START for that CLOCK cycle.
REQ-024 Other H edges SHALL increment V_COUNTER, saturating at 511.
REQ-025 FSM states SEARCH, ACQUIRE, LOCKED; reset state SEARCH.
REQ-026 SEARCH -> ACQUIRE on first H edge; match count cleared.
REQ-027 ACQUIRE: on each H edge, |new period - H_PERIOD_MEAS| <= H_TOL increments match count, otherwise clears it; count reaching LOCK_LINES -> LOCKED.
REQ-028 ACQUIRE or LOCKED -> SEARCH on timeout (REQ-022).
REQ-029 LOCKED -> SEARCH on any H edge whose period is outside H_TOL.
REQ-030 Period comparison SHALL use 10-bit signed difference; no wrap.
REQ-031 LOCKED = (state == LOCKED), registered.
REQ-032 ACTIVE = LOCKED and H_ACTIVE_START <= H_COUNTER < H_ACTIVE_START+H_PIXELS and V_ACTIVE_START <= V_COUNTER < V_ACTIVE_START+V_PIXELS, registered, one CLOCK after counters.
REQ-033 Between PIXEL_EN pulses, all state and outputs SHALL hold, except FRAME_START, which SHALL return low.

Reset
REQ-034 RESET_N low at a CLOCK edge: all counters, measurements, synchronizer flops (to 1), pending flag and match count SHALL be cleared, regardless of PIXEL_EN.
REQ-035 Reset outputs: H_COUNTER=0, V_COUNTER=0, H_PERIOD_MEAS=0, V_PERIOD_MEAS=0, LOCKED=0, ACTIVE=0, FRAME_START=0.
REQ-036 Reset asserted mid-frame SHALL return to SEARCH; relock SHALL need a full LOCK_LINES sequence.

Verification
REQ-037 PIXEL_EN every 16 CLOCKs; 400-pixel lines, H_SYNC low for 49 pixels; 260-line frames, V_SYNC low for 15 lines -> H_PERIOD_MEAS=400, LOCKED after 5th H edge, V_PERIOD_MEAS=260 from the 2nd frame.
REQ-038 Locked stream, one line stretched to 404 pixels -> LOCKED drops on that edge; relocks after 4 more 400-pixel lines.
REQ-039 Locked stream, one line 401 pixels -> LOCKED stays high (within H_TOL).
REQ-040 H_SYNC held high -> H_COUNTER saturates at 511, state SEARCH, LOCKED=0, ACTIVE=0.
REQ-041 V and H falling edges on same PIXEL_EN -> V_COUNTER=0 and single FRAME_START pulse that cycle.
REQ-042 RESET_N low for 1 CLOCK mid-line while locked -> all outputs zero next cycle; LOCKED returns after 5 H edges.
